// File: rtl/sd_sector_arbiter_if.sv
`default_nettype none
// ============================================================================
// sd_sector_arbiter_if : requester and SD-controller bundle for the arbiter
// Revision 1.0
// ============================================================================
interface sd_sector_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  op;
  logic [25:0] addr0;
  logic [25:0] addr1;
  logic [7:0]  wdata0;
  logic [7:0]  wdata1;
  logic [1:0]  gnt;
  logic [1:0]  byte_stb;
  logic [7:0]  rdata;
  logic [1:0]  done;
  logic [1:0]  err;
  logic        sd_execute;
  logic        sd_op_code;
  logic [25:0] sd_sector_address;
  logic [7:0]  sd_outgoing_byte;
  logic [7:0]  sd_incoming_byte;
  logic        sd_finished_byte;
  logic        sd_finished_sector;
  logic        sd_busy;

  // Arbiter side
  modport slave (
    input  req, op, addr0, addr1, wdata0, wdata1,
           sd_incoming_byte, sd_finished_byte, sd_finished_sector, sd_busy,
    output gnt, byte_stb, rdata, done, err,
           sd_execute, sd_op_code, sd_sector_address, sd_outgoing_byte
  );

  // Requester / controller side
  modport master (
    output req, op, addr0, addr1, wdata0, wdata1,
           sd_incoming_byte, sd_finished_byte, sd_finished_sector, sd_busy,
    input  gnt, byte_stb, rdata, done, err,
           sd_execute, sd_op_code, sd_sector_address, sd_outgoing_byte
  );
endinterface
`default_nettype wire

// File: rtl/sd_sector_arbiter.sv
`default_nettype none
// ============================================================================
// sd_sector_arbiter : round-robin sharing of one SD sector controller by two ports
// Revision 1.0
// ============================================================================
module sd_sector_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  sd_sector_arbiter_if.slave bus
);

  localparam int unsigned c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0] c_SECTOR_BYTES = 10'd512;
  localparam logic [9:0] c_CNT_MAX      = 10'd1023;

  localparam logic [2:0] c_S_IDLE        = 3'd0;
  localparam logic [2:0] c_S_WAIT_READY  = 3'd1;
  localparam logic [2:0] c_S_ISSUE       = 3'd2;
  localparam logic [2:0] c_S_WAIT_ACCEPT = 3'd3;
  localparam logic [2:0] c_S_TRANSFER    = 3'd4;
  localparam logic [2:0] c_S_FINISH      = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              op_q, op_d;
  logic [25:0]       addr_q, addr_d;
  logic              last_port_q, last_port_d;
  logic [9:0]        byte_cnt_q, byte_cnt_d;
  logic [c_TO_W-1:0] to_cnt_q, to_cnt_d;
  logic              err_flag_q, err_flag_d;
  logic [1:0]        byte_stb_q, byte_stb_d;
  logic [7:0]        rdata_q, rdata_d;

  logic              w_active;
  logic              w_timeout;
  logic              w_byte;
  logic [9:0]        w_cnt_next;
  logic              w_pick;

  // A byte reported while still waiting for acceptance is counted like any other
  assign w_active   = (state_q == c_S_WAIT_ACCEPT) || (state_q == c_S_TRANSFER);
  assign w_timeout  = w_active && (to_cnt_q == c_TO_LAST);
  assign w_byte     = w_active && bus.sd_finished_byte;
  assign w_cnt_next = (w_byte && (byte_cnt_q != c_CNT_MAX)) ? byte_cnt_q + 10'd1 : byte_cnt_q;
  assign w_pick     = (bus.req == 2'b11) ? ~last_port_q : ~bus.req[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_S_IDLE;
      gnt_q       <= 2'b00;
      op_q        <= 1'b0;
      addr_q      <= 26'd0;
      last_port_q <= 1'b1;
      byte_cnt_q  <= 10'd0;
      to_cnt_q    <= '0;
      err_flag_q  <= 1'b0;
      byte_stb_q  <= 2'b00;
      rdata_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      last_port_q <= last_port_d;
      byte_cnt_q  <= byte_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_flag_q  <= err_flag_d;
      byte_stb_q  <= byte_stb_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE:        if (bus.req != 2'b00) state_d = c_S_WAIT_READY;
      c_S_WAIT_READY:  if (!bus.sd_busy) state_d = c_S_ISSUE;
      c_S_ISSUE:       state_d = c_S_WAIT_ACCEPT;
      c_S_WAIT_ACCEPT: begin
        if (w_timeout) state_d = c_S_FINISH;
        else if (bus.sd_busy || bus.sd_finished_byte) state_d = c_S_TRANSFER;
      end
      c_S_TRANSFER:    if (w_timeout || bus.sd_finished_sector) state_d = c_S_FINISH;
      c_S_FINISH:      state_d = c_S_IDLE;
      default:         state_d = c_S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    last_port_d = last_port_q;
    byte_cnt_d  = byte_cnt_q;
    to_cnt_d    = to_cnt_q;
    err_flag_d  = err_flag_q;
    byte_stb_d  = 2'b00;
    rdata_d     = rdata_q;
    case (state_q)
      c_S_IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_d      = w_pick ? 2'b10 : 2'b01;
          op_d       = bus.op[w_pick];
          addr_d     = w_pick ? bus.addr1 : bus.addr0;
          err_flag_d = 1'b0;
        end
      end
      c_S_ISSUE: begin
        byte_cnt_d = 10'd0;
        to_cnt_d   = '0;
      end
      c_S_WAIT_ACCEPT, c_S_TRANSFER: begin
        byte_cnt_d = w_cnt_next;
        if (!w_timeout) to_cnt_d = to_cnt_q + 1'b1;
        if (w_byte) begin
          byte_stb_d = gnt_q;
          rdata_d    = bus.sd_incoming_byte;
        end
        // The count check sees a byte that lands together with the sector end
        if (w_timeout) err_flag_d = 1'b1;
        else if ((state_q == c_S_TRANSFER) && bus.sd_finished_sector &&
                 (w_cnt_next != c_SECTOR_BYTES)) err_flag_d = 1'b1;
      end
      c_S_FINISH: begin
        last_port_d = gnt_q[1];
        gnt_d       = 2'b00;
        op_d        = 1'b0;
        addr_d      = 26'd0;
      end
      default: ;
    endcase
  end

  assign bus.gnt               = gnt_q;
  assign bus.byte_stb          = byte_stb_q;
  assign bus.rdata             = rdata_q;
  assign bus.done              = (state_q == c_S_FINISH) ? gnt_q : 2'b00;
  assign bus.err               = ((state_q == c_S_FINISH) && err_flag_q) ? gnt_q : 2'b00;
  assign bus.sd_execute        = (state_q == c_S_ISSUE);
  assign bus.sd_op_code        = op_q;
  assign bus.sd_sector_address = addr_q;
  assign bus.sd_outgoing_byte  = gnt_q[0] ? bus.wdata0 : (gnt_q[1] ? bus.wdata1 : 8'd0);

endmodule
`default_nettype wire

// File: doc/sd_sector_arbiter.md
SD_SECTOR_ARBITER -- requirements
Module: sd_sector_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000: max cycles from sd_execute pulse to sd_finished_sector.
REQ-002 clk  input  1  master clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  2  per-port sector request; bit n = port n; held high until done[n].
REQ-005 op  input  2  per-port op code, 0 = READ, 1 = WRITE.
REQ-006 addr0, addr1  input  26 each  per-port sector address.
REQ-007 wdata0, wdata1  input  8 each  per-port write byte; must be valid while that port's byte_stb is pending.
REQ-008 gnt  output  2  one-hot grant; bit n high while port n owns the SD controller.
REQ-009 byte_stb  output  2  one-cycle pulse: byte n transferred for the granted port.
REQ-010 rdata  output  8  last read byte; valid on byte_stb.
REQ-011 done  output  2  one-cycle pulse: sector complete for port n.
REQ-012 err  output  2  one-cycle pulse with done: timeout or byte-count mismatch on port n.
REQ-013 sd_execute, sd_op_code  output  1 each  drive controller execute and op_code.
REQ-014 sd_sector_address  output  26 / sd_outgoing_byte  output  8  drive controller address and write byte.
REQ-015 sd_incoming_byte  input  8 / sd_finished_byte, sd_finished_sector, sd_busy  input  1 each  controller status.

Function
REQ-016 FSM states: IDLE, WAIT_READY, ISSUE, WAIT_ACCEPT, TRANSFER, FINISH.
REQ-017 IDLE: if req != 0, select a port (REQ-018), latch its op and addr, set gnt one-hot, go to WAIT_READY next cycle.
REQ-018 Round-robin: one requester -> grant it; both -> grant the port not granted last; last_port resets to 1, so port 0 wins the first tie.
REQ-019 Requests are sampled only in IDLE; a req change during a grant has no effect until return to IDLE.
REQ-020 WAIT_READY: stay while sd_busy = 1; go to ISSUE when sd_busy = 0.
REQ-021 ISSUE: sd_execute = 1 for exactly one cycle, clear the 10-bit byte counter and the timeout counter, go to WAIT_ACCEPT.
REQ-022 sd_op_code and sd_sector_address hold the latched values from the grant until FINISH.
REQ-023 sd_outgoing_byte = wdata of the granted port, combinationally muxed; 0 when no grant.
REQ-024 WAIT_ACCEPT: go to TRANSFER on sd_busy = 1 or on sd_finished_byte.
REQ-025 TRANSFER: each sd_finished_byte pulse increments the byte counter, pulses byte_stb[granted] the next cycle, and registers sd_incoming_byte into rdata.
REQ-026 Byte counter saturates at 1023; pulses beyond 512 still produce byte_stb.
REQ-027 TRANSFER exits to FINISH on sd_finished_sector.
REQ-028 If sd_finished_byte and sd_finished_sector coincide, count the byte first; the count check in REQ-029 includes it.
REQ-029 Mismatch: byte count != 512 at sd_finished_sector sets err.
REQ-030 Timeout counter runs in WAIT_ACCEPT and TRANSFER; reaching TIMEOUT_CYCLES forces FINISH with err set.
REQ-031 FINISH: for one cycle pulse done[granted] (and err[granted] if set), update last_port, clear gnt, return to IDLE.
REQ-032 Minimum gap between done and the next sd_execute is 3 cycles (IDLE, WAIT_READY, ISSUE).
REQ-033 gnt, byte_stb, done, and err are never high for both ports in the same cycle.

Reset
REQ-034 rst = 1 at a rising edge forces state IDLE, gnt = 0, byte_stb = 0, done = 0, err = 0, sd_execute = 0, sd_op_code = 0, sd_sector_address = 0, rdata = 0, counters = 0, last_port = 1.
REQ-035 Reset mid-transfer aborts with no done or err pulse; the controller is not reset by this block.
REQ-036 After rst deasserts, the first arbitration happens on the next cycle in which req != 0.

Verification
REQ-037 Single read: req = 01, op0 = 0, addr0 = 0x0000123; model returns 512 bytes then finished_sector -> gnt = 01; one sd_execute with address 0x0000123, op 0; 512 byte_stb[0]; done[0]; err = 0.
REQ-038 Tie: req = 11 held after reset -> port 0 is granted first; after done[0], port 1 is granted; with req = 11 still held, port 0 is granted next.
REQ-039 Write: req = 10, op1 = 1; model consumes 512 bytes -> sd_outgoing_byte tracks wdata1 on each byte; sd_op_code = 1; done[1].
REQ-040 Short sector: model signals finished_sector after 100 bytes -> done and err pulse together for the granted port.
REQ-041 Timeout: TIMEOUT_CYCLES = 50; model never responds after sd_execute -> done and err pulse 50 cycles after WAIT_ACCEPT entry; FSM returns to IDLE.
REQ-042 Busy hold-off plus reset: sd_busy = 1 at grant -> no sd_execute until sd_busy falls; then rst at byte 200 -> all outputs 0 next cycle, no done pulse.
